signed_int_to_float_conv: RTL and testbench

//   Converts a 32-bit two's-complement integer to an IEEE-754 single-precision value.

---
 rtl/signed_int_to_float_conv.sv | 69 ++++++
 tb/tb_signed_int_to_float_conv.sv | 133 +++++++++++++
 2 files changed

// File: rtl/signed_int_to_float_conv.sv
// 32-bit two's-complement integer to IEEE-754 single-precision converter.
// The conversion is combinational and round-to-nearest-even, and the output is registered (one cycle of latency).
module signed_int_to_float_conv (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] signed_int_val,
  output logic        [31:0] FP_val
);

  logic        sign_d;
  logic [31:0] mag_d;
  logic [4:0]  lz_d;
  logic [31:0] norm_d;
  logic [7:0]  exp_d;
  logic [31:0] fp_d;
  logic [31:0] fp_q;

  // Leading-zero count. The all-zero case is masked by the caller.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n[4:0];
  endfunction

  // RNE on a normalised magnitude (hidden 1 at bit 31). Returns {exp, mant}.
  // A mantissa carry-out bumps the exponent and leaves the mantissa at zero.
  function automatic logic [30:0] rne_pack(input logic [31:0] norm,
                                           input logic [7:0]  exp_in);
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [23:0] sum;
    mant   = norm[30:8];
    guard  = norm[7];
    sticky = |norm[6:0];
    inc    = guard & (sticky | mant[0]);
    sum    = {1'b0, mant} + {23'd0, inc};
    if (sum[23]) return {exp_in + 8'd1, 23'd0};
    else         return {exp_in, sum[22:0]};
  endfunction

  always_comb begin
    sign_d = signed_int_val[31];
    mag_d  = sign_d ? $unsigned(-signed_int_val) : $unsigned(signed_int_val);
    lz_d   = lzc32(mag_d);
    norm_d = mag_d << lz_d;
    exp_d  = 8'd158 - {3'b000, lz_d};
    fp_d   = 32'h0000_0000;
    if (mag_d != 32'd0) fp_d = {sign_d, rne_pack(norm_d, exp_d)};
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fp_q <= 32'h0000_0000;
    else        fp_q <= fp_d;
  end

  assign FP_val = fp_q;

endmodule

// File: tb/tb_signed_int_to_float_conv.sv
// Scoreboard bench for signed_int_to_float_conv. Expected values come from spec constants,
// or from a model that rounds the simulator's exact double-precision image of the integer.
module tb_signed_int_to_float_conv;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] din;
  logic        [31:0] dout;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  signed_int_to_float_conv dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .signed_int_val (din),
    .FP_val         (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  // Reference: round the exact double image of the integer to single precision.
  function automatic logic [31:0] ref_model(input logic signed [31:0] v);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    logic [22:0] keep;
    logic [28:0] rem;
    logic        up;
    logic [23:0] sum;
    logic [10:0] fe;
    if (v == 32'sd0) return 32'h0000_0000;
    r    = $itor(v);
    b    = $realtobits(r);
    e    = b[62:52];
    keep = b[51:29];
    rem  = b[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    sum  = {1'b0, keep} + {23'd0, up};
    fe   = e - 11'd1023 + 11'd127 + {10'd0, sum[23]};
    return {b[63], fe[7:0], sum[22:0]};
  endfunction

  task automatic send(input logic signed [31:0] v, input logic [31:0] want);
    @(negedge clk);
    din = v;
    exp_q.push_back(want);
  endtask

  // Each pushed stimulus is captured at the next rising edge; check just after it.
  always begin
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0) chk("data", dout, exp_q.pop_front());
  end

  initial begin
    rst_n = 1'b0;
    din   = 32'sh1234_5678;
    #2;
    chk("reset_async", dout, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", dout, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 32'sd1;
    exp_q.push_back(32'h3F80_0000);

    // Directed values
    send(32'sd0,           32'h0000_0000);
    send(32'sd1,           32'h3F80_0000);
    send(-32'sd1,          32'hBF80_0000);
    send(32'sd5,           32'h40A0_0000);
    send(-32'sd16,         32'hC180_0000);
    send(32'sh7FFF_FFFF,   32'h4F00_0000);
    send(32'sh8000_0000,   32'hCF00_0000);
    send(32'sd16777217,    32'h4B80_0000);
    send(32'sd16777219,    32'h4B80_0002);
    send(32'sd16777218,    32'h4B80_0001);
    send(-32'sd16777217,   32'hCB80_0000);
    send(32'sd1,           32'h3F80_0000);
    send(32'sd2,           32'h4000_0000);
    send(32'sd3,           32'h4040_0000);

    // Rounding boundaries near every magnitude above 2^24
    for (int k = 24; k < 31; k++) begin
      logic signed [31:0] base;
      base = 32'sd1 <<< k;
      send(base + 32'sd1,  ref_model(base + 32'sd1));
      send(base - 32'sd1,  ref_model(base - 32'sd1));
      send(-(base + 32'sd3), ref_model(-(base + 32'sd3)));
    end

    // Random sweep
    for (int i = 0; i < 1200; i++) begin
      logic signed [31:0] rv;
      rv = $random;
      if (i % 4 == 1) rv = rv >>> (i % 29);
      send(rv, ref_model(rv));
    end

    // Mid-stream reset clears the output at once
    send(32'sd5, 32'h40A0_0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", dout, 32'h0000_0000);
    @(negedge clk);
    din   = 32'sh7FFF_FFFF;
    rst_n = 1'b1;
    exp_q.push_back(32'h4F00_0000);
    send(-32'sd1, 32'hBF80_0000);

    @(posedge clk);
    #3;
    chk("drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
